// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
// Holds datapath width, reset PC, branch opcode and branch-history-table parameters.
package fetch_pkg;

    localparam int unsigned DBITS         = 32;
    localparam logic [31:0] START_PC      = 32'h0000_0040;
    localparam logic [3:0]  BR_OPCODE     = 4'h2;
    localparam int unsigned BHT_IDX_BITS  = 6;
    localparam logic [1:0]  BHT_RESET_VAL = 2'b01;

    // Two-bit saturating counter step: taken counts up to 3, not-taken down to 0.
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != 2'b11) begin
                nxt = ctr + 2'd1;
            end
        end else begin
            if (ctr != 2'b00) begin
                nxt = ctr - 2'd1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/Register.sv
// Generic enabled register with asynchronous active-high reset to a parameterised value.
// Used to hold the program counter of the fetch stage.
module Register #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wrtEn,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (wrtEn) begin
            data_d = dataIn;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign dataOut = data_q;

endmodule

// File: rtl/bht.sv
// Branch history table: 2^IDX_BITS two-bit saturating counters.
// One combinational read port and one synchronous update port; reads never see same-cycle updates.
module bht
    import fetch_pkg::*;
#(
    parameter int unsigned IDX_BITS = BHT_IDX_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [1:0]          rd_ctr,
    input  logic                upd_en,
    input  logic [IDX_BITS-1:0] upd_idx,
    input  logic                upd_taken
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;

    logic [1:0] ctr_q [ENTRIES];
    logic [1:0] ctr_d [ENTRIES];

    always_comb begin
        ctr_d = ctr_q;
        if (upd_en) begin
            ctr_d[upd_idx] = sat_update(ctr_q[upd_idx], upd_taken);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr_q[i] <= BHT_RESET_VAL;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, sequential/branch target adders and BHT-based prediction.
// Mispredict redirect beats stall, stall beats prediction, prediction beats sequential fetch.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      DBITS        = fetch_pkg::DBITS,
    parameter logic [DBITS-1:0] START_PC     = DBITS'(fetch_pkg::START_PC),
    parameter int unsigned      BHT_IDX_BITS = fetch_pkg::BHT_IDX_BITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [DBITS-1:0] imemData,
    input  logic             exValid,
    input  logic [DBITS-1:0] exPc,
    input  logic             exTaken,
    input  logic             exMispredict,
    input  logic [DBITS-1:0] exTarget,
    output logic [DBITS-1:0] imemAddr,
    output logic [DBITS-1:0] instWord,
    output logic [DBITS-1:0] pcIncremented,
    output logic [DBITS-1:0] brBaseOffset,
    output logic             prediction
);

    logic [DBITS-1:0]        pc_q;
    logic [DBITS-1:0]        pc_d;
    logic                    pc_we;
    logic                    redirect;
    logic                    is_branch;
    logic [DBITS-1:0]        imm_ext;
    logic [1:0]              lookup_ctr;
    logic [BHT_IDX_BITS-1:0] lookup_idx;
    logic [BHT_IDX_BITS-1:0] update_idx;
    logic                    unused_bits;

    assign redirect = exValid & exMispredict;
    assign pc_we    = !stall | redirect;

    assign imemAddr      = pc_q;
    assign instWord      = imemData;
    assign pcIncremented = pc_q + DBITS'(4);

    // Word offset: sign-extended 16-bit immediate scaled by 4.
    assign imm_ext      = {{(DBITS-18){imemData[15]}}, imemData[15:0], 2'b00};
    assign brBaseOffset = pcIncremented + imm_ext;

    assign is_branch  = (imemData[31:28] == BR_OPCODE);
    assign lookup_idx = pc_q[BHT_IDX_BITS+1:2];
    assign update_idx = exPc[BHT_IDX_BITS+1:2];
    assign prediction = is_branch & lookup_ctr[1];

    always_comb begin
        pc_d = pcIncremented;
        if (redirect) begin
            pc_d = {exTarget[DBITS-1:2], 2'b00};
        end else if (prediction) begin
            pc_d = brBaseOffset;
        end
    end

    Register #(
        .WIDTH     (DBITS),
        .RESET_VAL (START_PC)
    ) u_pc (
        .clk     (clk),
        .reset   (reset),
        .wrtEn   (pc_we),
        .dataIn  (pc_d),
        .dataOut (pc_q)
    );

    bht #(
        .IDX_BITS (BHT_IDX_BITS)
    ) u_bht (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (lookup_idx),
        .rd_ctr    (lookup_ctr),
        .upd_en    (exValid),
        .upd_idx   (update_idx),
        .upd_taken (exTaken)
    );

    // Address bits outside the BHT index and opcode-irrelevant fields are intentionally ignored.
    assign unused_bits = ^{exPc[DBITS-1:BHT_IDX_BITS+2], exPc[1:0], exTarget[1:0], imemData[27:16]};

endmodule
